// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined single-port memory between the fetch and data ports.
// Data wins by default; a starvation counter bounds how long fetch can be held off.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    logic [3:0]         starve;
    logic               starved;
    logic               win_i;
    logic               win_d;
    logic [MEM_LAT-1:0] tag_vld;
    owner_t             tag_own [MEM_LAT];

    always_comb begin
        starved = (starve == 4'(STARVE_MAX));
        win_i   = i_req & (~d_req | starved);
        win_d   = d_req & ~win_i;
    end

    // Grants are masked by reset so nothing reaches the memory while rst is low.
    assign i_gnt   = rst & win_i;
    assign d_gnt   = rst & win_d;
    assign m_en    = i_gnt | d_gnt;
    assign m_we    = d_gnt & d_we;
    assign m_addr  = win_d ? d_addr : i_addr;
    assign m_wdata = d_wdata;

    // Only counts while fetch is actually waiting; it can never pass STARVE_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (i_gnt || !i_req) begin
            starve <= '0;
        end else if (d_gnt) begin
            starve <= starve + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k < MEM_LAT; k++) begin
                tag_own[k] <= OWN_I;
            end
        end else begin
            tag_vld[0] <= m_en & ~m_we;
            tag_own[0] <= win_d ? OWN_D : OWN_I;
            for (int unsigned k = 1; k < MEM_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_own[k] <= tag_own[k-1];
            end
        end
    end

    assign i_rvalid = rst & tag_vld[MEM_LAT-1] & (tag_own[MEM_LAT-1] == OWN_I);
    assign d_rvalid = rst & tag_vld[MEM_LAT-1] & (tag_own[MEM_LAT-1] == OWN_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    always_comb begin
        assert (!(i_gnt && d_gnt));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: memory fixture plus a transaction-level reference model
// (winner rule, starvation count, queue of expected responses, shadow memory).
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] d_wdata, m_wdata, m_rdata, i_rdata, d_rdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory fixture: 256 words, read data valid LAT cycles after the command edge
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[0] <= mem[m_addr[9:2]];
        if (m_en && m_we) mem[m_addr[9:2]] <= m_wdata;
    end
    assign m_rdata = rd_pipe[LAT-1];

    // Reference model
    typedef struct {
        int            due;
        bit            own_d;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          rsp_q[$];
    logic [DW-1:0] shadow [256];
    int            m_starve = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // 0 = nobody, 1 = fetch, 2 = data
    function automatic int exp_win();
        if (!rst) return 0;
        if (i_req && (!d_req || m_starve == SMAX)) return 1;
        if (d_req) return 2;
        return 0;
    endfunction

    function automatic bit exp_rv(bit own_d);
        return rsp_q.size() > 0 && rsp_q[0].due == cyc && rsp_q[0].own_d == own_d;
    endfunction

    always @(posedge clk or negedge rst) begin
        int w;
        if (!rst) begin
            m_starve = 0;
            rsp_q.delete();
        end else begin
            w = exp_win();
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) void'(rsp_q.pop_front());
            if (w == 1) begin
                rsp_q.push_back(rsp_t'{due: cyc + LAT, own_d: 1'b0, data: shadow[i_addr[9:2]]});
            end else if (w == 2) begin
                if (d_we) shadow[d_addr[9:2]] = d_wdata;
                else rsp_q.push_back(rsp_t'{due: cyc + LAT, own_d: 1'b1, data: shadow[d_addr[9:2]]});
            end
            if (w == 1 || !i_req) m_starve = 0;
            else if (w == 2) m_starve++;
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, 255)) << 2;
    endfunction

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h10; d_addr = 32'h20; d_wdata = '0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_gnt: i_gnt=%b d_gnt=%b m_en=%b expected 0 0 0", i_gnt, d_gnt, m_en);
            end
            checks++;
            if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_rvalid: i_rvalid=%b d_rvalid=%b expected 0 0", i_rvalid, d_rvalid);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt);
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            checks++;
            if (d_rvalid !== exp_rv(1'b1) || i_rvalid !== exp_rv(1'b0)) begin
                failures++;
                $display("FAIL reset_drain: d_rvalid=%b i_rvalid=%b expected %b %b",
                         d_rvalid, i_rvalid, exp_rv(1'b1), exp_rv(1'b0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch();
        int seen = 0;
        for (int k = 0; k < 3; k++) begin
            i_req = 1'b1; i_addr = 32'h100 + 32'(4 * k);
            @(negedge clk);
            checks++;
            if (i_gnt !== 1'b1) begin
                failures++;
                $display("FAIL fetch_gnt: i_gnt=%b expected 1 (k=%0d)", i_gnt, k);
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            checks++;
            if (i_rvalid !== exp_rv(1'b0) || d_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL fetch_rvalid: i_rvalid=%b d_rvalid=%b expected %b 0",
                         i_rvalid, d_rvalid, exp_rv(1'b0));
            end
            if (exp_rv(1'b0)) begin
                seen++;
                checks++;
                if (i_rdata !== rsp_q[0].data) begin
                    failures++;
                    $display("FAIL fetch_data: i_rdata=%h expected %h", i_rdata, rsp_q[0].data);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 3) begin
            failures++;
            $display("FAIL fetch_count: responses=%0d expected 3", seen);
        end
    endtask

    task automatic test_store_load();
        int we_cnt = 0, rv_cnt = 0, gcyc = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || m_we !== 1'b1) begin
            failures++;
            $display("FAIL store_gnt: d_gnt=%b m_we=%b expected 1 1", d_gnt, m_we);
        end
        if (m_we === 1'b1) we_cnt++;
        @(posedge clk); #1;
        d_we = 1'b0;
        @(negedge clk);
        if (m_we === 1'b1) we_cnt++;
        gcyc = cyc;
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL load_gnt: d_gnt=%b expected 1", d_gnt);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (m_we === 1'b1) we_cnt++;
            if (d_rvalid === 1'b1) begin
                rv_cnt++;
                checks++;
                if (cyc - gcyc != LAT || d_rdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL load_data: latency=%0d data=%h expected %0d DEADBEEF",
                             cyc - gcyc, d_rdata, LAT);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rv_cnt != 1 || we_cnt != 1) begin
            failures++;
            $display("FAIL store_load_count: d_rvalid pulses=%0d m_we pulses=%0d expected 1 1", rv_cnt, we_cnt);
        end
    endtask

    task automatic test_contention();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = rnd_addr(); d_addr = rnd_addr();
        for (int k = 0; k < 2 * (SMAX + 1); k++) begin
            bit want_i;
            want_i = (k % (SMAX + 1)) == SMAX;
            @(negedge clk);
            checks++;
            if (i_gnt !== want_i || d_gnt !== !want_i) begin
                failures++;
                $display("FAIL contention_gnt: k=%0d i_gnt=%b d_gnt=%b expected %b %b",
                         k, i_gnt, d_gnt, want_i, !want_i);
            end
            checks++;
            if (i_rvalid !== exp_rv(1'b0) || d_rvalid !== exp_rv(1'b1)) begin
                failures++;
                $display("FAIL contention_route: i_rvalid=%b d_rvalid=%b expected %b %b",
                         i_rvalid, d_rvalid, exp_rv(1'b0), exp_rv(1'b1));
            end
            @(posedge clk); #1;
            if (want_i) i_addr = rnd_addr();
            else d_addr = rnd_addr();
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 1) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        bit ip = 1'b0, dp = 1'b0;
        int w;
        for (int n = 0; n < 400; n++) begin
            if (n < 380) begin
                if (!ip && $urandom_range(0, 2) != 0) begin ip = 1'b1; i_addr = rnd_addr(); end
                if (!dp && $urandom_range(0, 2) != 0) begin
                    dp = 1'b1; d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
                end
            end
            i_req = ip; d_req = dp;
            @(negedge clk);
            w = exp_win();
            checks++;
            if (i_gnt !== (w == 1) || d_gnt !== (w == 2) || m_en !== (w != 0) || m_we !== (w == 2 && d_we)) begin
                failures++;
                $display("FAIL random_gnt: n=%0d i_gnt=%b d_gnt=%b m_en=%b m_we=%b expected winner %0d we=%b",
                         n, i_gnt, d_gnt, m_en, m_we, w, d_we);
            end
            if (w != 0) begin
                checks++;
                if (m_addr !== (w == 1 ? i_addr : d_addr) || (w == 2 && d_we && m_wdata !== d_wdata)) begin
                    failures++;
                    $display("FAIL random_cmd: m_addr=%h m_wdata=%h expected %h %h",
                             m_addr, m_wdata, (w == 1 ? i_addr : d_addr), d_wdata);
                end
            end
            checks++;
            if (i_rvalid !== exp_rv(1'b0) || d_rvalid !== exp_rv(1'b1)) begin
                failures++;
                $display("FAIL random_rvalid: n=%0d i_rvalid=%b d_rvalid=%b expected %b %b",
                         n, i_rvalid, d_rvalid, exp_rv(1'b0), exp_rv(1'b1));
            end
            if (exp_rv(1'b0) || exp_rv(1'b1)) begin
                checks++;
                if ((exp_rv(1'b0) ? i_rdata : d_rdata) !== rsp_q[0].data) begin
                    failures++;
                    $display("FAIL random_data: n=%0d i_rdata=%h d_rdata=%h expected %h",
                             n, i_rdata, d_rdata, rsp_q[0].data);
                end
            end
            if (w == 1) ip = 1'b0;
            if (w == 2) dp = 1'b0;
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        logic [DW-1:0] want;
        i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_in_reset: i_rvalid=%b d_rvalid=%b expected 0 0", i_rvalid, d_rvalid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            checks++;
            if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL midflight_discard: i_rvalid=%b d_rvalid=%b expected 0 0", i_rvalid, d_rvalid);
            end
            @(posedge clk); #1;
        end
        i_req = 1'b1; i_addr = 32'h88;
        want = shadow[8'h22];
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            if (i_rvalid === 1'b1) begin
                seen++;
                checks++;
                if (i_rdata !== want) begin
                    failures++;
                    $display("FAIL midflight_next_data: i_rdata=%h expected %h", i_rdata, want);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL midflight_next_count: i_rvalid pulses=%0d expected 1", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k]    = 32'(k) * 32'h01010101 ^ 32'hA5A50000;
            shadow[k] = 32'(k) * 32'h01010101 ^ 32'hA5A50000;
        end
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_random();
        repeat (LAT + 2) begin @(posedge clk); #1; end
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
